tx_queue_arb: RTL and testbench

Round-robin frame arbiter that shares a single transmit data/pointer FIFO pair, the one drained by `mac_t`, between two frame sources. Each source presents its own standard-read FIFO pair: 8-bit data and a 16-bit length pointer `{5'b0, len[10:0]}`. The block moves one complete frame at a time from the granted source into the shared FIFOs. It writes every data byte before the matching pointer word, so `mac_t` never sees a pointer whose data is incomplete. It also withholds a frame until the shared data FIFO has room for all of it.

---
 rtl/tx_queue_arb.sv | 165 ++++++++++++++++
 tb/tb_tx_queue_arb.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_queue_arb.sv
// Round-robin frame arbiter: moves whole frames from two source FIFO pairs into one shared data/pointer FIFO pair.
// Latency: pointer read 1 cycle after detect, first byte written 5 cycles after detect, pointer written len+5 cycles after detect.
// Backpressure: a frame waits in CHECK until the pointer FIFO is not full and the data FIFO has room for the whole frame.
//
// Ports:
//   clk, rstn                        clock, asynchronous active-low reset
//   src_ptr_empty/src_ptr_rd         per-source pointer FIFO status and read strobe
//   src_ptr_dout0/1                  source pointer words {5'b0, len}, valid one cycle after read
//   src_data_rd, src_data_dout0/1    per-source data FIFO read strobe and bytes
//   data_fifo_din/wr/depth           shared data FIFO write port and occupancy
//   ptr_fifo_din/wr/full             shared pointer FIFO write port and full flag
//   grant                            one-hot source currently owning the shared FIFOs
//   drop                             one-cycle pulse when a zero-length frame is discarded
module tx_queue_arb #(
  parameter int DATA_SPACE_MAX = 4095
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  src_ptr_empty,
  output logic [1:0]  src_ptr_rd,
  input  logic [15:0] src_ptr_dout0,
  input  logic [15:0] src_ptr_dout1,
  output logic [1:0]  src_data_rd,
  input  logic [7:0]  src_data_dout0,
  input  logic [7:0]  src_data_dout1,
  output logic [7:0]  data_fifo_din,
  output logic        data_fifo_wr,
  input  logic [11:0] data_fifo_depth,
  output logic [15:0] ptr_fifo_din,
  output logic        ptr_fifo_wr,
  input  logic        ptr_fifo_full,
  output logic [1:0]  grant,
  output logic        drop
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PTR_RD  = 3'd1,
    PTR_LAT = 3'd2,
    CHECK   = 3'd3,
    COPY    = 3'd4,
    DRAIN   = 3'd5,
    PTR_WR  = 3'd6
  } state_t;

  localparam logic [12:0] SPACE_MAX = 13'(DATA_SPACE_MAX);

  state_t      state_q, state_d;
  logic        sel_q, sel_d;     // granted source index, held for the whole frame
  logic        last_q, last_d;   // source of the most recently finished or dropped frame
  logic [10:0] len_q, len_d;
  logic [10:0] cnt_q, cnt_d;     // remaining source data reads in COPY
  logic        data_wr_q;

  logic [1:0]  sel_onehot;
  logic [10:0] ptr_len;
  logic [12:0] space_sum;
  logic        unused_ptr_bits;

  assign sel_onehot = sel_q ? 2'b10 : 2'b01;
  assign ptr_len    = sel_q ? src_ptr_dout1[10:0] : src_ptr_dout0[10:0];
  // Widened so a nearly full FIFO plus a long frame cannot wrap and look like free space.
  assign space_sum  = {1'b0, data_fifo_depth} + {2'b00, len_q};

  // The upper pointer bits are reserved zeros; length lives in [10:0] only.
  assign unused_ptr_bits = ^{src_ptr_dout0[15:11], src_ptr_dout1[15:11]};

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_d       = last_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    src_ptr_rd   = 2'b00;
    src_data_rd  = 2'b00;
    ptr_fifo_wr  = 1'b0;
    ptr_fifo_din = 16'h0000;
    drop         = 1'b0;
    grant        = 2'b00;

    case (state_q)
      IDLE: begin
        if (src_ptr_empty != 2'b11) begin
          // Both pending: alternate away from the last winner; otherwise take the only one.
          if (src_ptr_empty == 2'b00) sel_d = ~last_q;
          else                        sel_d = src_ptr_empty[0];
          state_d = PTR_RD;
        end
      end

      PTR_RD: begin
        grant      = sel_onehot;
        src_ptr_rd = sel_onehot;
        state_d    = PTR_LAT;
      end

      PTR_LAT: begin
        grant = sel_onehot;
        len_d = ptr_len;
        if (ptr_len == 11'd0) begin
          drop    = 1'b1;
          last_d  = sel_q;
          state_d = IDLE;
        end else begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        grant = sel_onehot;
        // Space is only checked here: nothing else writes the shared FIFOs during COPY.
        if (!ptr_fifo_full && (space_sum <= SPACE_MAX)) begin
          cnt_d   = len_q;
          state_d = COPY;
        end
      end

      COPY: begin
        grant       = sel_onehot;
        src_data_rd = sel_onehot;
        cnt_d       = cnt_q - 11'd1;
        if (cnt_q == 11'd1) state_d = DRAIN;
      end

      DRAIN: begin
        // Last byte read in COPY is being written this cycle.
        grant   = sel_onehot;
        state_d = PTR_WR;
      end

      PTR_WR: begin
        grant        = sel_onehot;
        ptr_fifo_wr  = 1'b1;
        ptr_fifo_din = {5'b00000, len_q};
        last_d       = sel_q;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;   // source 0 wins the first contest after reset
      len_q     <= 11'd0;
      cnt_q     <= 11'd0;
      data_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      data_wr_q <= |src_data_rd;
    end
  end

  // Source bytes arrive one cycle after the read, aligned with the delayed strobe.
  assign data_fifo_wr  = data_wr_q;
  assign data_fifo_din = data_wr_q ? (sel_q ? src_data_dout1 : src_data_dout0) : 8'h00;

endmodule

// File: tb/tb_tx_queue_arb.sv
module tb_tx_queue_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  src_ptr_empty;
  logic [1:0]  src_ptr_rd;
  logic [15:0] src_ptr_dout0, src_ptr_dout1;
  logic [1:0]  src_data_rd;
  logic [7:0]  src_data_dout0, src_data_dout1;
  logic [7:0]  data_fifo_din;
  logic        data_fifo_wr;
  logic [11:0] data_fifo_depth;
  logic [15:0] ptr_fifo_din;
  logic        ptr_fifo_wr;
  logic        ptr_fifo_full;
  logic [1:0]  grant;
  logic        drop;

  always #5 clk = ~clk;

  tx_queue_arb #(.DATA_SPACE_MAX(4095)) dut (
    .clk(clk), .rstn(rstn),
    .src_ptr_empty(src_ptr_empty), .src_ptr_rd(src_ptr_rd),
    .src_ptr_dout0(src_ptr_dout0), .src_ptr_dout1(src_ptr_dout1),
    .src_data_rd(src_data_rd),
    .src_data_dout0(src_data_dout0), .src_data_dout1(src_data_dout1),
    .data_fifo_din(data_fifo_din), .data_fifo_wr(data_fifo_wr),
    .data_fifo_depth(data_fifo_depth),
    .ptr_fifo_din(ptr_fifo_din), .ptr_fifo_wr(ptr_fifo_wr),
    .ptr_fifo_full(ptr_fifo_full),
    .grant(grant), .drop(drop)
  );

  // ---------------- counters and scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] sp_q [2][$];   // source pointer FIFO contents
  logic [7:0]  sd_q [2][$];   // source data FIFO contents
  int          ml   [2][$];   // model: pending frame lengths per source
  logic [7:0]  mb   [2][$];   // model: pending bytes per source
  int          model_last;

  int          exp_grant[$];
  logic [7:0]  exp_data[$];
  logic [15:0] exp_ptr[$];
  int          exp_drop[$];
  int          grant_log[$];

  int frame_rd, frame_wr, rd_total, drop_cnt;
  int ptr_rd_cyc, first_rd_cyc, ptr_wr_cyc;
  bit prev_ptr_wr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Standard-read source FIFOs: data appears one cycle after the read strobe.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_ptr_empty  <= 2'b11;
      src_ptr_dout0  <= 16'h0;
      src_ptr_dout1  <= 16'h0;
      src_data_dout0 <= 8'h0;
      src_data_dout1 <= 8'h0;
    end else begin
      if (src_ptr_rd[0]  && sp_q[0].size() > 0) src_ptr_dout0  <= sp_q[0].pop_front();
      if (src_ptr_rd[1]  && sp_q[1].size() > 0) src_ptr_dout1  <= sp_q[1].pop_front();
      if (src_data_rd[0] && sd_q[0].size() > 0) src_data_dout0 <= sd_q[0].pop_front();
      if (src_data_rd[1] && sd_q[1].size() > 0) src_data_dout1 <= sd_q[1].pop_front();
      src_ptr_empty <= {sp_q[1].size() == 0, sp_q[0].size() == 0};
    end
  end

  // Monitor: compares every DUT output event against the expectation queues.
  always @(negedge clk) begin
    if (!rstn) begin
      frame_rd    = 0;
      frame_wr    = 0;
      prev_ptr_wr = 1'b0;
    end else begin
      if (prev_ptr_wr) chk("idle_after_ptr_wr", 32'(grant), 32'd0);
      prev_ptr_wr = ptr_fifo_wr;
      if (src_ptr_rd != 2'b00) begin
        ptr_rd_cyc = cyc;
        frame_rd   = 0;
        grant_log.push_back(int'(src_ptr_rd[1]));
        chk("ptr_rd_matches_grant", 32'(src_ptr_rd), 32'(grant));
        if (exp_grant.size() == 0) chk("unexpected_ptr_rd", 32'(src_ptr_rd), 32'd0);
        else chk("grant_src", 32'(src_ptr_rd[1]), 32'(exp_grant.pop_front()));
      end
      if (src_data_rd != 2'b00) begin
        if (frame_rd == 0) first_rd_cyc = cyc;
        frame_rd++;
        rd_total++;
        chk("data_rd_granted_only", 32'(src_data_rd), 32'(grant));
      end
      if (data_fifo_wr) begin
        if (exp_data.size() == 0) chk("unexpected_data_wr", 32'd1, 32'd0);
        else chk("data_byte", 32'(data_fifo_din), 32'(exp_data.pop_front()));
        frame_wr++;
      end
      if (ptr_fifo_wr) begin
        if (exp_ptr.size() == 0) chk("unexpected_ptr_wr", 32'd1, 32'd0);
        else chk("ptr_word", 32'(ptr_fifo_din), 32'(exp_ptr.pop_front()));
        chk("bytes_before_ptr", 32'(frame_wr), 32'(ptr_fifo_din));
        frame_wr   = 0;
        ptr_wr_cyc = cyc;
      end
      if (drop) begin
        drop_cnt++;
        chk("drop_no_write", {30'd0, data_fifo_wr, ptr_fifo_wr}, 32'd0);
        if (exp_drop.size() == 0) chk("unexpected_drop", 32'd1, 32'd0);
        else chk("drop_src", 32'(grant[1]), 32'(exp_drop.pop_front()));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load(input int s, input int len);
    logic [7:0] b;
    sp_q[s].push_back({5'b0, 11'(len)});
    ml[s].push_back(len);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      sd_q[s].push_back(b);
      mb[s].push_back(b);
    end
  endtask

  // Reference model: serve pending frames round-robin, alternating when both have work.
  task automatic predict();
    int s, l;
    while (ml[0].size() > 0 || ml[1].size() > 0) begin
      if (ml[0].size() > 0 && ml[1].size() > 0) s = 1 - model_last;
      else s = (ml[0].size() > 0) ? 0 : 1;
      l = ml[s].pop_front();
      exp_grant.push_back(s);
      if (l == 0) exp_drop.push_back(s);
      else begin
        for (int i = 0; i < l; i++) exp_data.push_back(mb[s].pop_front());
        exp_ptr.push_back({5'b0, 11'(l)});
      end
      model_last = s;
    end
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int  k = 0;
    bit  done = 1'b0;
    while (!done && k < budget) begin
      @(negedge clk);
      if (rnd) begin
        data_fifo_depth = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(3900, 4095))
                                                      : 12'($urandom_range(0, 3000));
        ptr_fifo_full   = ($urandom_range(0, 3) == 0);
      end
      k++;
      done = exp_grant.size() == 0 && exp_data.size() == 0 && exp_ptr.size() == 0 &&
             exp_drop.size() == 0 && grant == 2'b00 &&
             sp_q[0].size() == 0 && sp_q[1].size() == 0;
    end
    data_fifo_depth = 12'd0;
    ptr_fifo_full   = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_done: frames still outstanding after %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sp_q[s].delete(); sd_q[s].delete(); ml[s].delete(); mb[s].delete();
    end
    exp_grant.delete(); exp_data.delete(); exp_ptr.delete(); exp_drop.delete();
    model_last = 1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk(nm, {16'd0, src_ptr_rd, src_data_rd, grant, data_fifo_wr, ptr_fifo_wr, drop, data_fifo_din}, 32'd0);
    chk({nm, "_ptr_din"}, 32'(ptr_fifo_din), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int rd0, rel, d0, bound, len, r;
    rstn            = 1'b0;
    data_fifo_depth = 12'd0;
    ptr_fifo_full   = 1'b0;
    model_last      = 1;
    rd_total        = 0;
    drop_cnt        = 0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset_outputs");
    rstn = 1'b1;

    // Single frame: timing relative to detect (one cycle before the pointer read).
    @(negedge clk);
    load(0, 100);
    predict();
    wait_done(400, 1'b0);
    chk("single_rd_count", 32'(frame_rd), 32'd100);
    chk("single_first_rd", 32'(first_rd_cyc - ptr_rd_cyc), 32'd3);
    chk("single_ptr_wr", 32'(ptr_wr_cyc - ptr_rd_cyc), 32'd104);

    // Round-robin with three frames per source.
    do_reset();
    grant_log.delete();
    load(0, 60);   load(1, 60);
    load(0, 58);   load(1, 58);
    load(0, 1514); load(1, 1514);
    predict();
    wait_done(6000, 1'b0);
    chk("rr_count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < grant_log.size(); i++) chk("rr_order", 32'(grant_log[i]), 32'(i % 2));

    // Data-space back-pressure: 2600+1514 exceeds the limit, 2581+1514 fits exactly.
    data_fifo_depth = 12'd2600;
    rd0 = rd_total;
    load(0, 1514);
    predict();
    repeat (20) @(negedge clk);
    chk("bp_no_reads", 32'(rd_total - rd0), 32'd0);
    chk("bp_grant_held", 32'(grant), 32'd1);
    data_fifo_depth = 12'd2581;
    rel = cyc;
    bound = 0;
    while (rd_total == rd0 && bound < 10) begin @(negedge clk); bound++; end
    chk("bp_release_next_cycle", 32'(first_rd_cyc - rel), 32'd1);
    wait_done(3000, 1'b0);

    // Pointer FIFO full holds the frame.
    ptr_fifo_full = 1'b1;
    rd0 = rd_total;
    load(0, 50);
    predict();
    repeat (20) @(negedge clk);
    chk("pfull_no_reads", 32'(rd_total - rd0), 32'd0);
    ptr_fifo_full = 1'b0;
    wait_done(400, 1'b0);
    chk("pfull_reads_after", 32'(rd_total - rd0), 32'd50);

    // Zero-length frame on source 1, with source 0 also pending.
    grant_log.delete();
    d0 = drop_cnt;
    load(1, 0); load(0, 10); load(1, 5);
    predict();
    wait_done(400, 1'b0);
    chk("zero_drop_count", 32'(drop_cnt - d0), 32'd1);
    chk("zero_log_count", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() == 3) begin
      chk("zero_first_src1", 32'(grant_log[0]), 32'd1);
      chk("zero_then_src0", 32'(grant_log[1]), 32'd0);
      chk("zero_then_src1", 32'(grant_log[2]), 32'd1);
    end

    // Reset in the middle of a copy.
    load(0, 100);
    predict();
    bound = 0;
    while (frame_rd < 30 && bound < 200) begin @(negedge clk); bound++; end
    chk("midcopy_reached", 32'(frame_rd >= 30), 32'd1);
    #1 rstn = 1'b0;
    #1 chk_outputs_zero("midcopy_reset_outputs");
    do_reset();
    grant_log.delete();
    @(negedge clk);
    load(0, 40);
    predict();
    wait_done(300, 1'b0);
    chk("midcopy_resume_count", 32'(grant_log.size()), 32'd1);
    if (grant_log.size() == 1) chk("midcopy_resume_src", 32'(grant_log[0]), 32'd0);

    // Randomised batches with random back-pressure.
    for (int b = 0; b < 8; b++) begin
      for (int s = 0; s < 2; s++) begin
        r = $urandom_range(0, 3);
        for (int i = 0; i < r; i++) begin
          if (b == 3 && i == 0) len = 1600;
          else if ($urandom_range(0, 7) == 0) len = 0;
          else len = $urandom_range(1, 150);
          load(s, len);
        end
      end
      predict();
      wait_done(20000, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
